// File: rtl/tw_vgg_2iq_pkg.sv
// tw_vgg_2iq_pkg
//   Shared types and elaboration-time helpers for the ternary-weight IQ
//   classifier front end (tw_vgg_2iq).
//   - tern_t        : ternary weight code (ZERO / POS / NEG)
//   - tw_weight     : weight of filter c, tap t, channel ch (0 = I, 1 = Q)
//   - tw_acc_width  : width of the per-filter frame accumulator
//   - tw_narrow     : narrows a non-negative scaled sum to the score width
// Configuration macro: TW_VGG_2IQ_SAT_EN
//   defined   -> scores above the largest positive BW-bit value saturate
//   undefined -> scores keep only their low BW bits (wrap)
package tw_vgg_2iq_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } tern_t;

  // Container width used when narrowing scaled accumulators.
  localparam int unsigned NARROW_W = 64;

  // w(c,t,ch) = ((c+t+ch) mod 3) - 1 : residue 0 -> -1, 1 -> 0, 2 -> +1.
  function automatic tern_t tw_weight(input int unsigned c,
                                      input int unsigned t,
                                      input int unsigned ch);
    case ((c + t + ch) % 3)
      0:       return NEG;
      1:       return ZERO;
      default: return POS;
    endcase
  endfunction

  // One conv output needs BW+3 signed bits (six terms of magnitude <= 2^(BW-1));
  // summing 2^L2_IMG non-negative ReLU outputs adds L2_IMG bits.
  function automatic int unsigned tw_acc_width(input int unsigned bw,
                                               input int unsigned l2_img);
    return bw + 3 + l2_img;
  endfunction

  // Input is known non-negative, so only the upper bound matters.
  function automatic logic [NARROW_W-1:0] tw_narrow(input logic [NARROW_W-1:0] val,
                                                    input int unsigned         bw);
    logic [NARROW_W-1:0] lim;
`ifdef TW_VGG_2IQ_SAT_EN
    lim = (NARROW_W'(1) << (bw - 1)) - NARROW_W'(1);
    return (val > lim) ? lim : val;
`else
    lim = (NARROW_W'(1) << bw) - NARROW_W'(1);
    return val & lim;
`endif
  endfunction

endpackage

// File: rtl/tw_conv3_lane.sv
// tw_conv3_lane
//   One ternary 3-tap filter over the I and Q channels. Each accepted pair
//   produces two conv outputs (samples 2k and 2k+1); both go through ReLU and
//   their sum is registered as psum.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : cur/prev hold a freshly captured pair; load psum
//   cur      : pair 2k/2k+1   (lane 3 = I0, 2 = Q0, 1 = I1, 0 = Q1)
//   prev     : pair 2k-2/2k-1 (already zero at frame start)
//   psum     : relu(y[2k]) + relu(y[2k+1]), unsigned
module tw_conv3_lane
  import tw_vgg_2iq_pkg::*;
#(
  parameter int unsigned BW = 16,
  parameter int unsigned C  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0][BW-1:0]  cur,
  input  logic [3:0][BW-1:0]  prev,
  output logic [BW+2:0]       psum
);

  localparam int unsigned YW = BW + 3;  // signed conv output
  localparam int unsigned RW = BW + 2;  // ReLU output, sign bit dropped
  localparam int unsigned PW = BW + 3;  // sum of two ReLU outputs

  localparam tern_t W_I0 = tw_weight(C, 0, 0);
  localparam tern_t W_Q0 = tw_weight(C, 0, 1);
  localparam tern_t W_I1 = tw_weight(C, 1, 0);
  localparam tern_t W_Q1 = tw_weight(C, 1, 1);
  localparam tern_t W_I2 = tw_weight(C, 2, 0);
  localparam tern_t W_Q2 = tw_weight(C, 2, 1);

  // Weights are constants, so each tap folds to add, subtract or nothing.
  function automatic logic signed [YW-1:0] tap(input tern_t w, input logic [BW-1:0] x);
    logic signed [YW-1:0] xe;
    xe = {{3{x[BW-1]}}, x};
    case (w)
      POS:     return xe;
      NEG:     return -xe;
      default: return '0;
    endcase
  endfunction

  function automatic logic [RW-1:0] relu(input logic signed [YW-1:0] y);
    return y[YW-1] ? '0 : y[RW-1:0];
  endfunction

  logic signed [YW-1:0] y_even;
  logic signed [YW-1:0] y_odd;
  logic [PW-1:0]        psum_next;

  always_comb begin
    // y[2k]   : x[2k-2], x[2k-1], x[2k]
    y_even = tap(W_I0, prev[3]) + tap(W_Q0, prev[2])
           + tap(W_I1, prev[1]) + tap(W_Q1, prev[0])
           + tap(W_I2, cur[3])  + tap(W_Q2, cur[2]);
    // y[2k+1] : x[2k-1], x[2k], x[2k+1]
    y_odd  = tap(W_I0, prev[1]) + tap(W_Q0, prev[0])
           + tap(W_I1, cur[3])  + tap(W_Q1, cur[2])
           + tap(W_I2, cur[1])  + tap(W_Q2, cur[0]);
    psum_next = {1'b0, relu(y_even)} + {1'b0, relu(y_odd)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psum <= '0;
    end else if (en) begin
      psum <= psum_next;
    end
  end

endmodule

// File: rtl/tw_vgg_2iq.sv
// tw_vgg_2iq
//   Ternary-weight CNN front end for IQ modulation recognition. Two complex
//   samples per clock feed CH_OUT ternary 3-tap filters (tw_conv3_lane),
//   ReLU, and a global sum-pool over each frame of 2^L2_IMG samples. One
//   scaled score vector is emitted per frame.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   vld_in   : data_in holds a valid sample pair
//   data_in  : lane 3 = I(2k), 2 = Q(2k), 1 = I(2k+1), 0 = Q(2k+1)
//   vld_out  : one-cycle pulse, data_out updated with a frame result
//   data_out : per-filter score, (acc >>> R_SHIFT) narrowed to BW bits
// Pipeline: E capture pair, E+1 pair sums, E+2 accumulate, E+3 output.
// Configuration macro: TW_VGG_2IQ_SAT_EN (saturate scores instead of wrap).
module tw_vgg_2iq
  import tw_vgg_2iq_pkg::*;
#(
  parameter int unsigned BW      = 16,
  parameter int unsigned L2_IMG  = 10,
  parameter int unsigned R_SHIFT = 8,
  parameter int unsigned CH_OUT  = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_in,
  input  logic [3:0][BW-1:0]           data_in,
  output logic                         vld_out,
  output logic [CH_OUT-1:0][BW-1:0]    data_out
);

  localparam int unsigned AW = tw_acc_width(BW, L2_IMG);
  localparam int unsigned PW = BW + 3;
  localparam int unsigned CW = L2_IMG - 1;

  // Stage 0: pair capture and frame position
  logic [CW-1:0]            pair_cnt;
  logic [3:0][BW-1:0]       cur_pair;
  logic [3:0][BW-1:0]       prev_pair;
  logic                     vld_s0;
  logic                     first_s0;
  logic                     last_s0;

  // Stage 1: per-filter pair sums
  logic [CH_OUT-1:0][PW-1:0] psum;
  logic                      vld_s1;
  logic                      first_s1;
  logic                      last_s1;

  // Stage 2: frame accumulators
  logic [CH_OUT-1:0][AW-1:0] acc;
  logic                      vld_s2;

  // Valids advance every cycle so latency is fixed even across input gaps;
  // data registers only move when their valid is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt  <= '0;
      cur_pair  <= '0;
      prev_pair <= '0;
      vld_s0    <= 1'b0;
      first_s0  <= 1'b0;
      last_s0   <= 1'b0;
    end else begin
      vld_s0 <= vld_in;
      if (vld_in) begin
        cur_pair  <= data_in;
        // Zero history at frame start: no samples leak from the prior frame.
        prev_pair <= (pair_cnt == '0) ? '0 : cur_pair;
        first_s0  <= (pair_cnt == '0);
        last_s0   <= (pair_cnt == '1);
        pair_cnt  <= pair_cnt + CW'(1);
      end
    end
  end

  for (genvar c = 0; c < CH_OUT; c++) begin : g_lane
    tw_conv3_lane #(
      .BW (BW),
      .C  (c)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (vld_s0),
      .cur  (cur_pair),
      .prev (prev_pair),
      .psum (psum[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_s1   <= 1'b0;
      first_s1 <= 1'b0;
      last_s1  <= 1'b0;
    end else begin
      vld_s1 <= vld_s0;
      if (vld_s0) begin
        first_s1 <= first_s0;
        last_s1  <= last_s0;
      end
    end
  end

  // The first pair of a frame overwrites rather than adds, so a new frame
  // starts in the same cycle the previous total is being read out.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      vld_s2 <= 1'b0;
    end else begin
      vld_s2 <= vld_s1 & last_s1;
      if (vld_s1) begin
        for (int unsigned c = 0; c < CH_OUT; c++) begin
          acc[c] <= (first_s1 ? '0 : acc[c]) + AW'(psum[c]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_out  <= 1'b0;
      data_out <= '0;
    end else begin
      vld_out <= vld_s2;
      if (vld_s2) begin
        for (int unsigned c = 0; c < CH_OUT; c++) begin
          data_out[c] <= BW'(tw_narrow(NARROW_W'(acc[c] >> R_SHIFT), BW));
        end
      end
    end
  end

endmodule

// File: tb/tb_tw_vgg_2iq.sv
`timescale 1ns/1ps
module tb_tw_vgg_2iq;

  localparam int BW     = 16;
  localparam int L2_IMG = 10;
  localparam int CH_OUT = 24;
  localparam int FRAME  = 1 << L2_IMG;
  localparam int PAIRS  = FRAME / 2;

  typedef logic [CH_OUT-1:0][BW-1:0] vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               vld_in;
  logic [3:0][BW-1:0] data_in;
  logic               vld_out8, vld_out0;
  vec_t               data_out8, data_out0;

  tw_vgg_2iq #(.BW(BW), .L2_IMG(L2_IMG), .R_SHIFT(8), .CH_OUT(CH_OUT)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .vld_out(vld_out8), .data_out(data_out8)
  );

  tw_vgg_2iq #(.BW(BW), .L2_IMG(L2_IMG), .R_SHIFT(0), .CH_OUT(CH_OUT)) dut_s0 (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in),
    .vld_out(vld_out0), .data_out(data_out0)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result capture
  vec_t        res8_q[$];
  vec_t        res0_q[$];
  int unsigned rcyc_q[$];
  logic [1:0]  rflag_q[$];
  int unsigned lastk_q[$];

  always @(negedge clk) begin
    if (vld_out8 || vld_out0) begin
      res8_q.push_back(data_out8);
      res0_q.push_back(data_out0);
      rcyc_q.push_back(cyc);
      rflag_q.push_back({vld_out8, vld_out0});
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int si[2*FRAME];
  int sq[2*FRAME];

  // ---------------- reference model ----------------
  function automatic int wt(input int c, input int t, input int ch);
    return ((c + t + ch) % 3) - 1;
  endfunction

  function automatic logic [BW-1:0] exp_score(input longint acc, input int sh);
    longint     s;
    logic [63:0] bits;
    s = acc >>> sh;
`ifdef TW_VGG_2IQ_SAT_EN
    if (s > (longint'(1) <<< (BW-1)) - 1) s = (longint'(1) <<< (BW-1)) - 1;
`endif
    bits = 64'(s);
    return bits[BW-1:0];
  endfunction

  function automatic vec_t model_vec(input int base, input int sh);
    vec_t   v;
    longint acc;
    longint y;
    int     idx;
    for (int c = 0; c < CH_OUT; c++) begin
      acc = 0;
      for (int n = 0; n < FRAME; n++) begin
        y = 0;
        for (int t = 0; t < 3; t++) begin
          idx = n - 2 + t;
          if (idx >= 0)
            y += longint'(wt(c, t, 0)) * si[base+idx] + longint'(wt(c, t, 1)) * sq[base+idx];
        end
        if (y > 0) acc += y;
      end
      v[c] = exp_score(acc, sh);
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_stim();
    for (int i = 0; i < 2*FRAME; i++) begin
      si[i] = 0;
      sq[i] = 0;
    end
  endtask

  task automatic clear_queues();
    res8_q.delete(); res0_q.delete(); rcyc_q.delete(); rflag_q.delete(); lastk_q.delete();
  endtask

  task automatic drive(input int first_pair, input int npairs, input int gap_pct);
    for (int p = first_pair; p < first_pair + npairs; p++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        vld_in  = 1'b0;
        data_in = {$urandom, $urandom};
        @(negedge clk);
      end
      vld_in     = 1'b1;
      data_in[3] = BW'(si[2*p]);
      data_in[2] = BW'(sq[2*p]);
      data_in[1] = BW'(si[2*p+1]);
      data_in[0] = BW'(sq[2*p+1]);
      @(negedge clk);
      if ((p + 1) % PAIRS == 0) lastk_q.push_back(cyc);
    end
    vld_in  = 1'b0;
    data_in = '0;
  endtask

  task automatic wait_results(input int n);
    int budget = 40;
    while (res8_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; vld_in = 1'b1; data_in = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    vld_in = 1'b0; data_in = '0;
    @(negedge clk);
    n_checks++;
    if (vld_out8 !== 1'b0 || vld_out0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_vld: got %b%b required 00", vld_out8, vld_out0);
    end
    n_checks++;
    if (data_out8 !== '0) begin
      n_fail++; $display("FAIL reset_data8: got %h required 0", data_out8);
    end
    n_checks++;
    if (data_out0 !== '0) begin
      n_fail++; $display("FAIL reset_data0: got %h required 0", data_out0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    vec_t got8, got0;
    int unsigned rc, lk;
    clear_stim(); clear_queues();
    drive(0, 2*PAIRS, 0);
    wait_results(2);
    n_checks++;
    if (res8_q.size() != 2) begin
      n_fail++; $display("FAIL zero_count: got %0d results required 2", res8_q.size());
    end
    for (int f = 0; f < 2 && res8_q.size() > 0; f++) begin
      got8 = res8_q.pop_front(); got0 = res0_q.pop_front(); rc = rcyc_q.pop_front();
      void'(rflag_q.pop_front());
      if (lastk_q.size() > 0) begin
        lk = lastk_q.pop_front();
        n_checks++;
        if (rc - lk != 3) begin
          n_fail++; $display("FAIL zero_latency f%0d: got %0d required 3", f, rc - lk);
        end
      end
      n_checks++;
      if (got8 !== '0 || got0 !== '0) begin
        n_fail++; $display("FAIL zero_data f%0d: got %h / %h required 0", f, got8, got0);
      end
    end
  endtask

  task automatic test_impulse();
    int   vi[4] = '{512, -512, 0, 512};
    int   vq[4] = '{0, 0, 512, 512};
    vec_t exp8, exp0, got8, got0;
    for (int v = 0; v < 4; v++) begin
      clear_stim(); clear_queues();
      si[100] = vi[v]; sq[100] = vq[v];
      exp8 = model_vec(0, 8); exp0 = model_vec(0, 0);
      drive(0, PAIRS, 0);
      wait_results(1);
      n_checks++;
      if (res8_q.size() != 1) begin
        n_fail++; $display("FAIL impulse%0d_count: got %0d required 1", v, res8_q.size());
      end
      if (res8_q.size() > 0) begin
        got8 = res8_q.pop_front(); got0 = res0_q.pop_front();
        for (int c = 0; c < CH_OUT; c++) begin
          n_checks++;
          if (got8[c] !== exp8[c] || got0[c] !== exp0[c]) begin
            n_fail++;
            $display("FAIL impulse%0d ch%0d: got %h/%h required %h/%h", v, c, got8[c], got0[c], exp8[c], exp0[c]);
          end
        end
      end
    end
  endtask

  task automatic test_frame_edge();
    vec_t exp8[2], got8, got0;
    clear_stim(); clear_queues();
    si[FRAME-1] = 512;
    exp8[0] = model_vec(0, 8); exp8[1] = model_vec(FRAME, 8);
    drive(0, 2*PAIRS, 0);
    wait_results(2);
    n_checks++;
    if (res8_q.size() != 2) begin
      n_fail++; $display("FAIL edge_count: got %0d required 2", res8_q.size());
    end
    for (int f = 0; f < 2 && res8_q.size() > 0; f++) begin
      got8 = res8_q.pop_front(); got0 = res0_q.pop_front();
      for (int c = 0; c < CH_OUT; c++) begin
        n_checks++;
        if (got8[c] !== exp8[f][c]) begin
          n_fail++; $display("FAIL edge f%0d ch%0d: got %h required %h", f, c, got8[c], exp8[f][c]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    vec_t exp8, got8;
    int unsigned rc, lk;
    logic [1:0] fl;
    clear_stim(); clear_queues();
    si[100] = 512;
    exp8 = model_vec(0, 8);
    drive(0, PAIRS, 30);
    wait_results(1);
    n_checks++;
    if (res8_q.size() != 1) begin
      n_fail++; $display("FAIL gaps_count: got %0d required 1", res8_q.size());
    end
    if (res8_q.size() > 0) begin
      got8 = res8_q.pop_front(); void'(res0_q.pop_front());
      rc = rcyc_q.pop_front(); fl = rflag_q.pop_front();
      n_checks++;
      if (fl !== 2'b11) begin
        n_fail++; $display("FAIL gaps_vld_both: got %b required 11", fl);
      end
      if (lastk_q.size() > 0) begin
        lk = lastk_q.pop_front();
        n_checks++;
        if (rc - lk != 3) begin
          n_fail++; $display("FAIL gaps_latency: got %0d required 3", rc - lk);
        end
      end
      for (int c = 0; c < CH_OUT; c++) begin
        n_checks++;
        if (got8[c] !== exp8[c]) begin
          n_fail++; $display("FAIL gaps ch%0d: got %h required %h", c, got8[c], exp8[c]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    vec_t exp8, got8, got0;
    logic [BW-1:0] exp_ovf;
`ifdef TW_VGG_2IQ_SAT_EN
    exp_ovf = 16'h7FFF;
`else
    exp_ovf = 16'hFF00;
`endif
    clear_stim(); clear_queues();
    for (int m = 0; m < FRAME / 4; m++) si[4*m] = 32767;
    exp8 = model_vec(0, 8);
    drive(0, PAIRS, 0);
    wait_results(1);
    n_checks++;
    if (res8_q.size() != 1) begin
      n_fail++; $display("FAIL ovf_count: got %0d required 1", res8_q.size());
    end
    if (res8_q.size() > 0) begin
      got8 = res8_q.pop_front(); got0 = res0_q.pop_front();
      for (int c = 0; c < CH_OUT; c++) begin
        n_checks++;
        if (got0[c] !== exp_ovf || got8[c] !== exp8[c]) begin
          n_fail++;
          $display("FAIL ovf ch%0d: got %h/%h required %h/%h", c, got0[c], got8[c], exp_ovf, exp8[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    vec_t exp8[2], exp0[2], got8, got0;
    int unsigned rc, lk;
    clear_stim(); clear_queues();
    for (int i = 0; i < 2*FRAME; i++) begin
      si[i] = int'($urandom_range(65535)) - 32768;
      sq[i] = int'($urandom_range(65535)) - 32768;
    end
    for (int f = 0; f < 2; f++) begin
      exp8[f] = model_vec(f*FRAME, 8);
      exp0[f] = model_vec(f*FRAME, 0);
    end
    drive(0, 2*PAIRS, 20);
    wait_results(2);
    n_checks++;
    if (res8_q.size() != 2) begin
      n_fail++; $display("FAIL random_count: got %0d required 2", res8_q.size());
    end
    for (int f = 0; f < 2 && res8_q.size() > 0; f++) begin
      got8 = res8_q.pop_front(); got0 = res0_q.pop_front(); rc = rcyc_q.pop_front();
      void'(rflag_q.pop_front());
      if (lastk_q.size() > 0) begin
        lk = lastk_q.pop_front();
        n_checks++;
        if (rc - lk != 3) begin
          n_fail++; $display("FAIL random_latency f%0d: got %0d required 3", f, rc - lk);
        end
      end
      for (int c = 0; c < CH_OUT; c++) begin
        n_checks++;
        if (got8[c] !== exp8[f][c] || got0[c] !== exp0[f][c]) begin
          n_fail++;
          $display("FAIL random f%0d ch%0d: got %h/%h required %h/%h", f, c, got8[c], got0[c], exp8[f][c], exp0[f][c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t exp8, got8;
    clear_stim(); clear_queues();
    for (int i = 0; i < FRAME; i++) begin
      si[i] = int'($urandom_range(65535)) - 32768;
      sq[i] = int'($urandom_range(65535)) - 32768;
    end
    si[FRAME+100] = 512;
    exp8 = model_vec(FRAME, 8);
    drive(0, 300, 0);
    rst = 1'b1; vld_in = 1'b1; data_in = {$urandom, $urandom};
    repeat (2) @(negedge clk);
    rst = 1'b0; vld_in = 1'b0; data_in = '0;
    @(negedge clk);
    drive(PAIRS, PAIRS, 0);
    wait_results(1);
    n_checks++;
    if (res8_q.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d required 1", res8_q.size());
    end
    if (res8_q.size() > 0) begin
      got8 = res8_q.pop_front();
      for (int c = 0; c < CH_OUT; c++) begin
        n_checks++;
        if (got8[c] !== exp8[c]) begin
          n_fail++; $display("FAIL rstmid ch%0d: got %h required %h", c, got8[c], exp8[c]);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    vld_in  = 1'b0;
    data_in = '0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_impulse();
    test_frame_edge();
    test_gaps();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
